sbox_layer_iter: RTL and testbench

SBOX_LAYER_ITER -- requirements
Module: sbox_layer_iter

---
 rtl/ascon_pack.sv | 17 +
 rtl/sbox.sv | 32 +++
 rtl/sbox_layer_iter.sv | 115 +++++++++++
 tb/tb_sbox_layer_iter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon types: the 5x64 permutation state and the sbox-layer FSM state.
package ascon_pack;

    localparam int NB_WORDS  = 5;
    localparam int WORD_BITS = 64;
    localparam int COL_BITS  = 6;

    // Word 0 is x0, word 4 is x4.
    typedef logic [NB_WORDS-1:0][WORD_BITS-1:0] ascon_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_t;

endpackage

// File: rtl/sbox.sv
// Ascon 5-bit substitution box in its bitsliced boolean form.
// Bit 4 of x/y is x0, bit 0 is x4.
module sbox (
    input  logic [4:0] x,
    output logic [4:0] y
);

    logic a0, a1, a2, a3, a4;
    logic b0, b1, b2, b3, b4;

    // Input mixing: x0 ^= x4, x4 ^= x3, x2 ^= x1.
    assign a0 = x[4] ^ x[0];
    assign a1 = x[3];
    assign a2 = x[2] ^ x[3];
    assign a3 = x[1];
    assign a4 = x[0] ^ x[1];

    // Chi-like nonlinear layer.
    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    // Output mixing: x1 ^= x0, x0 ^= x4, x3 ^= x2, x2 = ~x2.
    assign y[4] = b0 ^ b4;
    assign y[3] = b1 ^ b0;
    assign y[2] = ~b2;
    assign y[1] = b3 ^ b2;
    assign y[0] = b4;

endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative Ascon substitution layer: COLS_PER_CYCLE columns per clock,
// valid/ready handshake on both sides, IDLE -> RUN -> DONE control.
module sbox_layer_iter
    import ascon_pack::*;
#(
    parameter int COLS_PER_CYCLE = 16
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  ascon_state_t state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

    localparam int                  NB_STEPS = WORD_BITS / COLS_PER_CYCLE;
    localparam logic [COL_BITS-1:0] COL_STEP = COL_BITS'(COLS_PER_CYCLE);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'((NB_STEPS - 1) * COLS_PER_CYCLE);

    fsm_state_t                          fsm;
    logic         [COL_BITS-1:0]         col;
    ascon_state_t                        state_q;
    ascon_state_t                        state_next;
    logic         [NB_WORDS-1:0][COLS_PER_CYCLE-1:0] chunk_in;
    logic         [NB_WORDS-1:0][COLS_PER_CYCLE-1:0] chunk_out;

    // col is always a multiple of COLS_PER_CYCLE, so the active chunk is a part-select.
    always_comb begin
        for (int i = 0; i < NB_WORDS; i++) begin
            chunk_in[i] = state_q[i][col +: COLS_PER_CYCLE];
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        logic [4:0] sb_x;
        logic [4:0] sb_y;

        assign sb_x = {chunk_in[0][k], chunk_in[1][k], chunk_in[2][k],
                       chunk_in[3][k], chunk_in[4][k]};

        sbox u_sbox (
            .x(sb_x),
            .y(sb_y)
        );

        assign chunk_out[0][k] = sb_y[4];
        assign chunk_out[1][k] = sb_y[3];
        assign chunk_out[2][k] = sb_y[2];
        assign chunk_out[3][k] = sb_y[1];
        assign chunk_out[4][k] = sb_y[0];
    end

    // NOTE: default the whole word first so untouched columns pass through and no latch is inferred.
    always_comb begin
        state_next = state_q;
        for (int i = 0; i < NB_WORDS; i++) begin
            state_next[i][col +: COLS_PER_CYCLE] = chunk_out[i];
        end
    end

    // NOTE: all state, including the working register, uses non-blocking assignments and async reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm     <= IDLE;
            col     <= '0;
            state_q <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (valid_i) begin
                        fsm     <= RUN;
                        col     <= '0;
                        state_q <= state_i;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= state_next;
                    if (col == LAST_COL) begin
                        fsm     <= DONE;
                        col     <= '0;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                    end else begin
                        col <= col + COL_STEP;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        fsm     <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    col     <= '0;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Self-checking bench: three instances (1, 16 and 64 columns per cycle) against a
// column-wise table model of the Ascon sbox layer.
module tb_sbox_layer_iter;
    import ascon_pack::*;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int LAT [3] = '{64, 4, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in  [3];
    logic         ready_in  [3];
    ascon_state_t state_in  [3];
    logic         ready_out [3];
    logic         valid_out [3];
    logic         busy_out  [3];
    ascon_state_t state_out [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sbox_layer_iter #(.COLS_PER_CYCLE(1)) dut_c1 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid_in[0]), .ready_o(ready_out[0]),
        .state_i(state_in[0]), .valid_o(valid_out[0]), .ready_i(ready_in[0]),
        .state_o(state_out[0]), .busy_o(busy_out[0]));

    sbox_layer_iter #(.COLS_PER_CYCLE(16)) dut_c16 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid_in[1]), .ready_o(ready_out[1]),
        .state_i(state_in[1]), .valid_o(valid_out[1]), .ready_i(ready_in[1]),
        .state_o(state_out[1]), .busy_o(busy_out[1]));

    sbox_layer_iter #(.COLS_PER_CYCLE(64)) dut_c64 (
        .clock_i(clk), .reset_i(rst), .valid_i(valid_in[2]), .ready_o(ready_out[2]),
        .state_i(state_in[2]), .valid_o(valid_out[2]), .ready_i(ready_in[2]),
        .state_o(state_out[2]), .busy_o(busy_out[2]));

    function automatic ascon_state_t ref_layer(input ascon_state_t s);
        ascon_state_t r;
        logic [4:0]   c_in;
        logic [4:0]   c_out;
        for (int j = 0; j < 64; j++) begin
            c_in  = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            c_out = SBOX[c_in];
            for (int i = 0; i < 5; i++) r[i][j] = c_out[4-i];
        end
        return r;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    // Present s to DUT d, count edges to valid_o, compare latency and result; leaves DUT in DONE.
    task automatic run_and_check(input int d, input ascon_state_t s, input string name);
        int lat;
        bit seen;
        ascon_state_t exp_s;
        exp_s = ref_layer(s);
        @(negedge clk);
        valid_in[d] = 1'b1;
        state_in[d] = s;
        ready_in[d] = 1'b0;
        @(posedge clk);
        #1;
        valid_in[d] = 1'b0;
        checks++;
        if (busy_out[d] !== 1'b1 || ready_out[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy d=%0d: busy=%b ready=%b, required busy=1 ready=0",
                     name, d, busy_out[d], ready_out[d]);
        end
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (valid_out[d] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout d=%0d: no valid_o within 200 edges", name, d);
        end else begin
            if (lat !== LAT[d]) begin
                failures++;
                $display("FAIL %s_latency d=%0d: got %0d edges, required %0d", name, d, lat, LAT[d]);
            end
            checks++;
            if (state_out[d] !== exp_s) begin
                failures++;
                $display("FAIL %s_data d=%0d: got %h required %h", name, d, state_out[d], exp_s);
            end
        end
    endtask

    task automatic release_done(input int d, input string name);
        @(negedge clk);
        ready_in[d] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid_out[d] !== 1'b0 || ready_out[d] !== 1'b1 || busy_out[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s_release d=%0d: valid=%b ready=%b busy=%b, required 0 1 0",
                     name, d, valid_out[d], ready_out[d], busy_out[d]);
        end
        @(negedge clk);
        ready_in[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            valid_in[d] = 1'b0;
            ready_in[d] = 1'b0;
            state_in[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (valid_out[d] !== 1'b0 || busy_out[d] !== 1'b0 || state_out[d] !== '0) begin
                failures++;
                $display("FAIL reset_hold d=%0d: valid=%b busy=%b state=%h, required 0 0 0",
                         d, valid_out[d], busy_out[d], state_out[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready_out[d] !== 1'b1 || valid_out[d] !== 1'b0 || busy_out[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release d=%0d: ready=%b valid=%b busy=%b, required 1 0 0",
                         d, ready_out[d], valid_out[d], busy_out[d]);
            end
        end
    endtask

    task automatic test_all_zero();
        run_and_check(1, '0, "zero");
        checks++;
        if (state_out[1][2] !== 64'hFFFF_FFFF_FFFF_FFFF || state_out[1][0] !== 64'h0 ||
            state_out[1][1] !== 64'h0 || state_out[1][3] !== 64'h0 || state_out[1][4] !== 64'h0) begin
            failures++;
            $display("FAIL zero_words: got %h, required x2 all-ones and other words zero", state_out[1]);
        end
        release_done(1, "zero");
    endtask

    task automatic test_all_ones();
        ascon_state_t ones;
        ones = '1;
        for (int d = 0; d < 3; d++) begin
            run_and_check(d, ones, "ones");
            checks++;
            if (state_out[d][1] !== 64'h0 || state_out[d][0] !== '1 || state_out[d][2] !== '1 ||
                state_out[d][3] !== '1 || state_out[d][4] !== '1) begin
                failures++;
                $display("FAIL ones_words d=%0d: got %h, required x1 zero and other words all-ones",
                         d, state_out[d]);
            end
            release_done(d, "ones");
        end
    endtask

    task automatic test_random_hold();
        ascon_state_t snap;
        for (int n = 0; n < 6; n++) begin
            run_and_check(n % 3, rand_state(), "random");
            if (n == 1) begin
                snap = state_out[1];
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checks++;
                    if (state_out[1] !== snap || valid_out[1] !== 1'b1) begin
                        failures++;
                        $display("FAIL hold_stable cycle=%0d: valid=%b state=%h, required 1 %h",
                                 c, valid_out[1], state_out[1], snap);
                    end
                end
            end
            release_done(n % 3, "random");
        end
    endtask

    task automatic test_ignore_valid();
        ascon_state_t s1;
        ascon_state_t s2;
        ascon_state_t exp1;
        bit seen;
        s1   = rand_state();
        s2   = rand_state();
        exp1 = ref_layer(s1);
        @(negedge clk);
        valid_in[1] = 1'b1;
        state_in[1] = s1;
        ready_in[1] = 1'b0;
        @(posedge clk);
        #1;
        state_in[1] = s2;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid_out[1] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!seen || state_out[1] !== exp1 || valid_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL ignore_done: seen=%b valid=%b got %h required %h",
                     seen, valid_out[1], state_out[1], exp1);
        end
        @(negedge clk);
        ready_in[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_out[1] !== 1'b1 || busy_out[1] !== 1'b0 || state_out[1] !== exp1) begin
            failures++;
            $display("FAIL ignore_handoff: ready=%b busy=%b got %h required ready=1 busy=0 %h",
                     ready_out[1], busy_out[1], state_out[1], exp1);
        end
        @(negedge clk);
        valid_in[1] = 1'b0;
        ready_in[1] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_out[1] !== 1'b1 || state_out[1] !== exp1) begin
            failures++;
            $display("FAIL ignore_idle: ready=%b got %h required ready=1 %h",
                     ready_out[1], state_out[1], exp1);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        valid_in[1] = 1'b1;
        state_in[1] = rand_state();
        @(posedge clk);
        #1;
        valid_in[1] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ready_out[1] !== 1'b1 || busy_out[1] !== 1'b0 || valid_out[1] !== 1'b0 ||
            state_out[1] !== '0) begin
            failures++;
            $display("FAIL midrun_reset: ready=%b busy=%b valid=%b state=%h, required 1 0 0 0",
                     ready_out[1], busy_out[1], valid_out[1], state_out[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid_out[1] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL midrun_no_valid: got %0d valid cycles, required 0", pulses);
        end
        run_and_check(1, rand_state(), "after_reset");
        release_done(1, "after_reset");
    endtask

    task automatic test_back_to_back();
        ascon_state_t pending[$];
        ascon_state_t exp_s;
        int last_acc;
        int accepts;
        int outputs;
        last_acc = -1;
        accepts  = 0;
        outputs  = 0;
        ready_in[1] = 1'b1;
        for (int cyc = 0; cyc < 75; cyc++) begin
            @(negedge clk);
            valid_in[1] = (cyc < 60);
            if (valid_out[1] === 1'b1) begin
                outputs++;
                checks++;
                if (pending.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_output cycle=%0d: got %h with nothing pending",
                             cyc, state_out[1]);
                end else begin
                    exp_s = pending.pop_front();
                    if (state_out[1] !== exp_s) begin
                        failures++;
                        $display("FAIL b2b_data cycle=%0d: got %h required %h", cyc, state_out[1], exp_s);
                    end
                end
            end
            state_in[1] = rand_state();
            if (valid_in[1] && ready_out[1] === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        failures++;
                        $display("FAIL b2b_spacing cycle=%0d: got %0d cycles, required 6",
                                 cyc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
                pending.push_back(ref_layer(state_in[1]));
            end
        end
        checks++;
        if (accepts < 9 || outputs != accepts || pending.size() != 0) begin
            failures++;
            $display("FAIL b2b_counts: accepts=%0d outputs=%0d pending=%0d, required >=9 equal 0",
                     accepts, outputs, pending.size());
        end
        @(negedge clk);
        valid_in[1] = 1'b0;
        ready_in[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_all_ones();
        test_random_hold();
        test_ignore_valid();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
